// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: log2(WIDTH)-level barrel shifter (SLL, SRL, SRA, ROR) behind a
// valid/ready stream with a single global stall.
// Build option BARREL_SHIFTER_PIPE_STAGES_EN: when defined, every mux level is followed by
// a register (latency SW); when undefined, all levels are combinational into one output
// register (latency 1). Handshake, reset values and results are identical in both builds.
module barrel_shifter_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSrl = 2'b01;
    localparam logic [1:0] OpSra = 2'b10;

    logic advance;

    // The whole pipeline moves only when the output slot is free or being drained
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // One 2:1 mux level: shift by 2^lvl when en is set, otherwise pass through
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input logic             en,
        input int unsigned      lvl,
        input logic [1:0]       op,
        input logic             sign
    );
        logic [WIDTH-1:0] top_mask;  // positions vacated at the MSB end by a right shift
        logic [WIDTH-1:0] r;
        int unsigned      s;
        s        = 32'd1 << lvl;
        top_mask = ~({WIDTH{1'b1}} >> s);
        case (op)
            OpSll:   r = d << s;
            OpSrl:   r = d >> s;
            OpSra:   r = (d >> s) | (sign ? top_mask : '0);
            default: r = (d >> s) | (d << (WIDTH - s));
        endcase
        return en ? r : d;
    endfunction

`ifdef BARREL_SHIFTER_PIPE_STAGES_EN
    // Each level carries its own copy of op, shamt and the original sign bit
    logic [WIDTH-1:0] st_data_q  [SW];
    logic [WIDTH-1:0] st_data_d  [SW];
    logic [SW-1:0]    st_shamt_q [SW];
    logic [SW-1:0]    st_shamt_d [SW];
    logic [1:0]       st_op_q    [SW];
    logic [1:0]       st_op_d    [SW];
    logic [SW-1:0]    st_sign_q;
    logic [SW-1:0]    st_sign_d;
    logic [SW-1:0]    st_valid_q;
    logic [SW-1:0]    st_valid_d;
    logic             zero_q;
    logic             unused_ctrl;

    // Next state per level: level 0 works on the input beat, level k on register k-1
    always_comb begin
        st_data_d  = '{default: '0};
        st_shamt_d = '{default: '0};
        st_op_d    = '{default: '0};
        st_sign_d  = '0;
        st_valid_d = '0;
        st_data_d[0]  = shift_level(in_data, in_shamt[0], 0, in_op, in_data[WIDTH-1]);
        st_shamt_d[0] = in_shamt;
        st_op_d[0]    = in_op;
        st_sign_d[0]  = in_data[WIDTH-1];
        st_valid_d[0] = in_valid;
        for (int k = 1; k < int'(SW); k++) begin
            st_data_d[k]  = shift_level(st_data_q[k-1], st_shamt_q[k-1][k], k,
                                        st_op_q[k-1], st_sign_q[k-1]);
            st_shamt_d[k] = st_shamt_q[k-1];
            st_op_d[k]    = st_op_q[k-1];
            st_sign_d[k]  = st_sign_q[k-1];
            st_valid_d[k] = st_valid_q[k-1];
        end
    end

    // Level registers, all gated by the global stall; valid bits included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(SW); k++) begin
                st_data_q[k]  <= '0;
                st_shamt_q[k] <= '0;
                st_op_q[k]    <= '0;
            end
            st_sign_q  <= '0;
            st_valid_q <= '0;
            zero_q     <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < int'(SW); k++) begin
                st_data_q[k]  <= st_data_d[k];
                st_shamt_q[k] <= st_shamt_d[k];
                st_op_q[k]    <= st_op_d[k];
            end
            st_sign_q  <= st_sign_d;
            st_valid_q <= st_valid_d;
            zero_q     <= (st_data_d[SW-1] == '0);
        end
    end

    // Control copies past their last use (final level, consumed shamt bits) are dead
    always_comb begin
        unused_ctrl = 1'b0;
        for (int k = 0; k < int'(SW); k++) begin
            unused_ctrl = unused_ctrl ^ (^{st_shamt_q[k], st_op_q[k], st_sign_q[k]});
        end
    end

    assign out_valid = st_valid_q[SW-1];
    assign out_data  = st_data_q[SW-1];
    assign out_zero  = zero_q;
`else
    logic [WIDTH-1:0] shifted;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             zero_q;

    // Ripple the operand through every mux level combinationally
    always_comb begin
        shifted = in_data;
        for (int k = 0; k < int'(SW); k++) begin
            shifted = shift_level(shifted, in_shamt[k], k, in_op, in_data[WIDTH-1]);
        end
    end

    // Single output register, held while the downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b0;
        end else if (advance) begin
            valid_q <= in_valid;
            data_q  <= shifted;
            zero_q  <= (shifted == '0);
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_zero  = zero_q;
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: directed and streaming checks for barrel_shifter_pipe at WIDTH=8.
module tb_barrel_shifter_pipe;

`ifdef BARREL_SHIFTER_PIPE_STAGES_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [7:0] d;
        logic [2:0] s;
        logic [1:0] op;
        logic [7:0] e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [2:0] in_shamt = '0;
    logic [1:0] in_op = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_zero;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];

    // Hand-computed directed vectors: {data, shamt, op, expected}
    vec_t vecs [16] = '{
        '{8'h81, 3'd1, 2'b00, 8'h02}, '{8'h80, 3'd7, 2'b01, 8'h01},
        '{8'h80, 3'd1, 2'b00, 8'h00}, '{8'h80, 3'd3, 2'b10, 8'hF0},
        '{8'h70, 3'd3, 2'b10, 8'h0E}, '{8'h81, 3'd1, 2'b11, 8'hC0},
        '{8'h0F, 3'd4, 2'b11, 8'hF0}, '{8'hA5, 3'd0, 2'b00, 8'hA5},
        '{8'hA5, 3'd0, 2'b01, 8'hA5}, '{8'hA5, 3'd0, 2'b10, 8'hA5},
        '{8'hA5, 3'd0, 2'b11, 8'hA5}, '{8'hFF, 3'd7, 2'b10, 8'hFF},
        '{8'h01, 3'd7, 2'b11, 8'h02}, '{8'h01, 3'd1, 2'b01, 8'h00},
        '{8'h96, 3'd5, 2'b01, 8'h04}, '{8'h96, 3'd2, 2'b10, 8'hE5}
    };

    always #5 clk = ~clk;

    barrel_shifter_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    // Bit-by-bit reference: result bit i is taken from source bit i-sh or i+sh
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int sh,
                                             input logic [1:0] op);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            case (op)
                2'b00:   r[i] = (i >= sh) ? d[i-sh] : 1'b0;
                2'b01:   r[i] = (i + sh < 8) ? d[i+sh] : 1'b0;
                2'b10:   r[i] = (i + sh < 8) ? d[i+sh] : d[7];
                default: r[i] = d[(i+sh)%8];
            endcase
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero: got %b want 0", out_zero); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_modes();
        out_ready = 1'b1;
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = vecs[v].d;
            in_shamt = vecs[v].s;
            in_op    = vecs[v].op;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (LAT - 1) @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mode_valid[%0d]: got %b want 1", v, out_valid); end
            checks++; if (out_data !== vecs[v].e) begin errors++; $display("FAIL mode_data[%0d]: got %h want %h", v, out_data, vecs[v].e); end
            checks++; if (out_zero !== (vecs[v].e == 8'h00)) begin errors++; $display("FAIL mode_zero[%0d]: got %b want %b", v, out_zero, vecs[v].e == 8'h00); end
        end
        repeat (LAT + 1) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        int got = 0;
        exp_q.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 16 + LAT + 2; c++) begin
            @(negedge clk);
            if (c >= LAT && c < 16 + LAT) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[c%0d]: got %b want 1", c, out_valid); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra[c%0d]: got %h want none", c, out_data);
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    if (out_data !== e || out_zero !== (e == 8'h00)) begin
                        errors++; $display("FAIL b2b_data[c%0d]: got %h/%b want %h/%b", c, out_data, out_zero, e, e == 8'h00);
                    end
                end
            end
            in_valid = (c < 16);
            in_data  = 8'($urandom);
            in_shamt = 3'($urandom);
            in_op    = 2'($urandom);
            #1;
            if (in_valid && in_ready) exp_q.push_back(ref_shift(in_data, int'(in_shamt), in_op));
        end
        in_valid = 1'b0;
        checks++; if (got != 16) begin errors++; $display("FAIL b2b_count: got %0d want 16", got); end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got = 0;
        logic stalled = 1'b0;
        logic [7:0] held = '0;
        logic [7:0] e;
        logic [7:0] bd = 8'($urandom);
        logic [2:0] bs = 3'($urandom);
        logic [1:0] bo = 2'($urandom);
        exp_q.delete();
        for (int c = 0; c < 60 && got < 10; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c < 9);
            if (out_valid && !out_ready) begin
                if (stalled) begin
                    checks++; if (out_data !== held) begin errors++; $display("FAIL bp_stable[c%0d]: got %h want %h", c, out_data, held); end
                end
                held = out_data;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra[c%0d]: got %h want none", c, out_data);
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    if (out_data !== e) begin errors++; $display("FAIL bp_data[c%0d]: got %h want %h", c, out_data, e); end
                end
            end
            in_valid = (sent < 10);
            in_data  = bd;
            in_shamt = bs;
            in_op    = bo;
            #1;
            if (out_valid && !out_ready) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[c%0d]: got %b want 0", c, in_ready); end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_shift(bd, int'(bs), bo));
                sent++;
                bd = 8'($urandom);
                bs = 3'($urandom);
                bo = 2'($urandom);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (got != 10) begin errors++; $display("FAIL bp_count: got %0d want 10", got); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_leftover: got %0d want 0", exp_q.size()); end
        repeat (LAT + 1) @(negedge clk);
    endtask

    task automatic test_bubbles();
        logic expv;
        logic [7:0] e;
        exp_q.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 8 + LAT + 2; c++) begin
            @(negedge clk);
            expv = (c >= LAT && c < LAT + 8) ? (((c - LAT) % 2) == 0) : 1'b0;
            checks++; if (out_valid !== expv) begin errors++; $display("FAIL bubble_valid[c%0d]: got %b want %b", c, out_valid, expv); end
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bubble_extra[c%0d]: got %h want none", c, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin errors++; $display("FAIL bubble_data[c%0d]: got %h want %h", c, out_data, e); end
                end
            end
            in_valid = (c < 8) && ((c % 2) == 0);
            in_data  = 8'($urandom);
            in_shamt = 3'($urandom);
            in_op    = 2'($urandom);
            #1;
            if (in_valid && in_ready) exp_q.push_back(ref_shift(in_data, int'(in_shamt), in_op));
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        in_shamt = 3'd0;
        in_op    = 2'b00;
        repeat (LAT + 3) @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 8'h3C) begin errors++; $display("FAIL full_data: got %h want 3c", out_data); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL async_data: got %h want 00", out_data); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL async_zero: got %b want 0", out_zero); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_in_ready: got %b want 1", in_ready); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < LAT + 3; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_valid[c%0d]: got %b want 0", c, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
